radix4_booth_mul_seq: RTL and testbench
=======================================

// Module: radix4_booth_mul_seq
// PURPOSE
//  Iterative radix-4 Booth multiplier for the EXU; one Booth digit per cycle. XLEN-parametrised.
//  Covers MUL/MULH/MULHSU/MULHU plus word (MULW) mode. Provides flush and a ready/valid result port with backpressure.
//  Sits beside the ALU: the EXU issues on in_*, and the writeback side drains on out_*.
// PARAMETERS
//  XLEN  64  operand width; even.
//  WLEN  32  word-mode operand width; even, < XLEN.
// PORTS
//  clock      in   1       clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       abort current op; pipeline redirect
//  in_valid   in   1       op request
//  in_ready   out  1       request accepted when in_valid & in_ready
//  word       in   1       1: use a[WLEN-1:0], b[WLEN-1:0]
//  sign_mode  in   2       {a_signed,b_signed}: 00 uu, 01 us, 10 su, 11 ss
//  a          in   XLEN    multiplicand
//  b          in   XLEN    multiplier
//  out_valid  out  1       result valid; held until out_ready
//  out_ready  in   1       consumer accepts the result
//  res_hi     out  XLEN    high half of the product
//  res_lo     out  XLEN    low half of the product
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, res_hi=res_lo=0, in_ready=1 on the first cycle after reset.
//  FSM IDLE->BUSY on accept; BUSY->DONE after last digit; DONE->IDLE on out_valid&out_ready.
//  Any state->IDLE on flush; flush has priority over all other events.
//  in_ready = (state==IDLE) & ~flush. No new op is accepted in BUSY or DONE.
//  Operand extension: a is sign- or zero-extended to 2*XLEN into reg M.
//    b (or its low WLEN bits) is extended to N+2 bits into reg Q, with prev bit q_-1=0.
//    N=XLEN, or WLEN in word mode. Digits D = N/2+1: 33 (XLEN=64) or 17 (word mode).
//  Per BUSY cycle:
//    digit = -2*q1 + q0 + q_-1, giving a partial product in {0, +-M, +-2M}.
//    Negation is done as ~x+1. P += pp, modulo 2^(2*XLEN).
//    Then M <<= 2, Q >>= 2 (arithmetic), q_-1 <= old q1.
//  Accumulator P is 2*XLEN bits and fixed-position. It is cleared on accept. The result is exact for all sign modes.
//  Latency: out_valid rises D cycles after the accept edge. res_* are stable while out_valid=1.
//  Result, full mode: res_hi=P[2XLEN-1:XLEN], res_lo=P[XLEN-1:0].
//  Result, word mode: res_lo=sext(P[WLEN-1:0]), res_hi=sext(P[2WLEN-1:WLEN]).
//  res_* hold their last value in IDLE. They update only on the BUSY->DONE transition.
//  Flush in BUSY discards the op with no out_valid. Flush in DONE drops the pending result.
//  Flush together with in_valid in IDLE means the request is not accepted.
//  sign_mode, word, a and b are sampled only at the accept edge. Later changes are ignored.
// CONFIGURATION
//  RADIX4_BOOTH_MUL_EARLY_EXIT_EN defined:
//    After each digit, if the remaining Q bits and q_-1 are all 0 or all 1, go BUSY->DONE.
//    All remaining digits are then zero. At least 1 digit is always processed; latency is 1..D.
//  Not defined: latency is always exactly D.
// STRUCTURE
//  Shared package/define file holds:
//    state encodings IDLE/BUSY/DONE
//    sign-mode codes MUL_UU/US/SU/SS
//    Booth digit codes (ZERO, P1, P2, N1, N2)
//  Sub-module booth_r4_pp_gen: combinational. Inputs {q1,q0,q_-1} and M; output 2*XLEN-bit partial product.
//  The top level holds the FSM, the digit counter, and the M/Q/P registers.
// TESTING
//  1. uu, a=b=0xFFFF_FFFF_FFFF_FFFF -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x1, out_valid 33 cycles after accept (no EN).
//  2. ss, a=-1, b=0x8000_0000_0000_0000 -> hi=0x0, lo=0x8000_0000_0000_0000.
//  3. su, a=-2, b=0xFFFF_FFFF_FFFF_FFFF -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x2.
//  4. word ss, a=0x7FFF_FFFF, b=2 -> lo=0xFFFF_FFFF_FFFF_FFFE, hi=0x0, latency 17.
//  5. out_ready=0 for 5 cycles after out_valid -> out_valid/res_* stable, in_ready=0. Then accept, IDLE next cycle.
//  6. flush in cycle 10 of BUSY -> IDLE next edge, no out_valid. A following uu op 3*5 -> lo=15.
//     With EN: b=3 -> out_valid after 2 cycles.

Source files
------------

// File: rtl/radix4_booth_mul_seq_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states, sign-mode codes,
// Booth digit codes and the digit decoder.
package radix4_booth_mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // sign_mode = {a_signed, b_signed}
    localparam logic [1:0] MUL_UU = 2'b00;
    localparam logic [1:0] MUL_US = 2'b01;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_SS = 2'b11;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        N1   = 3'd3,
        N2   = 3'd4
    } booth_dig_e;

    // {q1, q0, q_-1} -> digit = -2*q1 + q0 + q_-1
    function automatic booth_dig_e booth_decode(input logic [2:0] sel);
        booth_dig_e d;
        case (sel)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = N2;
            3'b101, 3'b110: d = N1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: selects 0, +-M or +-2M
// from one Booth digit window.
module booth_r4_pp_gen
    import radix4_booth_mul_seq_pkg::*;
#(
    parameter int W = 128
) (
    input  logic [2:0]   sel_i,
    input  logic [W-1:0] m_i,
    output logic [W-1:0] pp_o
);

    booth_dig_e dig;
    logic [W-1:0] m2;

    assign dig = booth_decode(sel_i);
    assign m2  = m_i << 1;

    always_comb begin
        pp_o = '0;
        case (dig)
            P1:      pp_o = m_i;
            P2:      pp_o = m2;
            N1:      pp_o = ~m_i + W'(1);
            N2:      pp_o = ~m2 + W'(1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/radix4_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, full and word modes.
// Optional early termination: define RADIX4_BOOTH_MUL_EARLY_EXIT_EN.
module radix4_booth_mul_seq
    import radix4_booth_mul_seq_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            word,
    input  logic [1:0]      sign_mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);

    localparam int PW     = 2 * XLEN;
    localparam int QW     = XLEN + 2;
    localparam int D_FULL = XLEN / 2 + 1;
    localparam int D_WORD = WLEN / 2 + 1;
    localparam int CW     = $clog2(D_FULL);

    state_e          state_q, state_d;
    logic [PW-1:0]   m_q, p_q;
    logic [QW-1:0]   q_q;
    logic            qm1_q;
    logic [CW-1:0]   cnt_q;
    logic            word_q;
    logic [XLEN-1:0] res_hi_q, res_lo_q;

    logic            accept, a_sgn, b_sgn, last_digit;
    logic [PW-1:0]   a_ext, pp, p_sum, m_nx;
    logic [QW-1:0]   b_ext, q_nx;
    logic [XLEN-1:0] fin_hi, fin_lo;

    assign in_ready  = (state_q == IDLE) & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;

    assign a_sgn = (sign_mode == MUL_SU) | (sign_mode == MUL_SS);
    assign b_sgn = (sign_mode == MUL_US) | (sign_mode == MUL_SS);

    // Q is sign/zero extended to the full register so the arithmetic shift keeps word mode exact.
    always_comb begin
        if (word) begin
            a_ext = {{(PW-WLEN){a_sgn & a[WLEN-1]}}, a[WLEN-1:0]};
            b_ext = {{(QW-WLEN){b_sgn & b[WLEN-1]}}, b[WLEN-1:0]};
        end else begin
            a_ext = {{XLEN{a_sgn & a[XLEN-1]}}, a};
            b_ext = {{2{b_sgn & b[XLEN-1]}}, b};
        end
    end

    booth_r4_pp_gen #(.W(PW)) u_pp_gen (
        .sel_i (q_q[1:0] == 2'b00 && !qm1_q ? 3'b000 : {q_q[1:0], qm1_q}),
        .m_i   (m_q),
        .pp_o  (pp)
    );

    assign p_sum = p_q + pp;
    assign m_nx  = m_q << 2;
    assign q_nx  = {{2{q_q[QW-1]}}, q_q[QW-1:2]};

`ifdef RADIX4_BOOTH_MUL_EARLY_EXIT_EN
    // Remaining multiplier bits all equal (incl. q_-1) means every later digit is zero.
    assign last_digit = (cnt_q == '0) | (&{q_nx, q_q[1]}) | ~(|{q_nx, q_q[1]});
`else
    assign last_digit = (cnt_q == '0);
`endif

    always_comb begin
        if (word_q) begin
            fin_lo = {{(XLEN-WLEN){p_sum[WLEN-1]}}, p_sum[WLEN-1:0]};
            fin_hi = {{(XLEN-WLEN){p_sum[2*WLEN-1]}}, p_sum[2*WLEN-1:WLEN]};
        end else begin
            fin_lo = p_sum[XLEN-1:0];
            fin_hi = p_sum[PW-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last_digit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_q      <= '0;
            p_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            word_q   <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else if (accept) begin
            m_q    <= a_ext;
            q_q    <= b_ext;
            qm1_q  <= 1'b0;
            p_q    <= '0;
            word_q <= word;
            cnt_q  <= word ? CW'(D_WORD - 1) : CW'(D_FULL - 1);
        end else if (state_q == BUSY && !flush) begin
            m_q   <= m_nx;
            q_q   <= q_nx;
            qm1_q <= q_q[1];
            p_q   <= p_sum;
            cnt_q <= cnt_q - CW'(1);
            if (last_digit) begin
                res_hi_q <= fin_hi;
                res_lo_q <= fin_lo;
            end
        end
    end

endmodule

// File: tb/tb_radix4_booth_mul_seq.sv
// Self-checking bench: transaction-level product/latency model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_radix4_booth_mul_seq;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, word, out_valid, out_ready;
    logic [1:0]  sign_mode;
    logic [63:0] a, b, res_hi, res_lo;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;

`ifdef RADIX4_BOOTH_MUL_EARLY_EXIT_EN
    localparam int LAT_WORD_B2 = 2;
    localparam int LAT_B3      = 2;
`else
    localparam int LAT_WORD_B2 = 17;
    localparam int LAT_B3      = 33;
`endif

    radix4_booth_mul_seq #(.XLEN(64), .WLEN(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word      (word),
        .sign_mode (sign_mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Exact product from plain integer arithmetic, returned as {hi, lo}.
    function automatic logic [127:0] model_prod(input bit w, input logic [1:0] sm,
                                                input logic [63:0] av, input logic [63:0] bv);
        logic [127:0] x, y, p;
        if (w) begin
            x = {{96{sm[1] & av[31]}}, av[31:0]};
            y = {{96{sm[0] & bv[31]}}, bv[31:0]};
        end else begin
            x = {{64{sm[1] & av[63]}}, av};
            y = {{64{sm[0] & bv[63]}}, bv};
        end
        p = x * y;
        if (w) return {{32{p[63]}}, p[63:32], {32{p[31]}}, p[31:0]};
        return p;
    endfunction

    function automatic int model_lat(input bit w, input bit bs, input logic [63:0] bv);
        int d;
`ifdef RADIX4_BOOTH_MUL_EARLY_EXIT_EN
        logic signed [129:0] be, rem;
        be = w ? {{98{bs & bv[31]}}, bv[31:0]} : {{66{bs & bv[63]}}, bv};
`endif
        d = w ? 17 : 33;
`ifdef RADIX4_BOOTH_MUL_EARLY_EXIT_EN
        for (int k = 1; k <= d; k++) begin
            rem = be >>> (2 * k);
            if ((rem == 0 && !be[2*k-1]) || (rem == -1 && be[2*k-1])) return k;
        end
`endif
        return d;
    endfunction

    // Transaction model: 0 idle, 1 computing, 2 result pending
    int           mst = 0;
    int           mcnt = 0;
    logic [127:0] m_pend = '0;
    logic [63:0]  e_hi = '0, e_lo = '0;

    always @(posedge clock) begin
        if (reset) begin
            mst = 0; e_hi = '0; e_lo = '0;
        end else if (flush) begin
            mst = 0;
        end else begin
            case (mst)
                0: if (in_valid) begin
                    m_pend = model_prod(word, sign_mode, a, b);
                    mcnt   = model_lat(word, sign_mode[0], b);
                    mst    = 1;
                end
                1: begin
                    mcnt--;
                    if (mcnt == 0) begin
                        mst = 2; e_hi = m_pend[127:64]; e_lo = m_pend[63:0];
                    end
                end
                default: if (out_ready) mst = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (armed && !reset) begin
            chk("cyc_out_valid", 128'(out_valid), 128'(mst == 2));
            chk("cyc_in_ready", 128'(in_ready), 128'(mst == 0 && !flush));
            chk("cyc_res_hi", 128'(res_hi), 128'(e_hi));
            chk("cyc_res_lo", 128'(res_lo), 128'(e_lo));
        end
    end

    // Issue one op, wait for out_valid (bounded), check result; leaves it pending (out_ready=0).
    task automatic run_op(input string nm, input bit w, input logic [1:0] sm,
                          input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] ehi, input logic [63:0] elo, input int elat);
        int n;
        chk({nm, "_pre_ready"}, 128'(in_ready), 128'(1));
        word = w; sign_mode = sm; a = av; b = bv; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; word = ~w; sign_mode = ~sm;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        n = 0;
        do begin
            @(posedge clock); #1; n++;
        end while (!out_valid && n < 60);
        if (!out_valid) chk({nm, "_timeout"}, 128'(0), 128'(1));
        else if (elat >= 0) chk({nm, "_latency"}, 128'(n), 128'(elat));
        chk({nm, "_hi"}, 128'(res_hi), 128'(ehi));
        chk({nm, "_lo"}, 128'(res_lo), 128'(elo));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] hold_hi, hold_lo;
        bit seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        word = 1'b0; sign_mode = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        armed = 1'b1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_res", {res_hi, res_lo}, 128'(0));

        run_op("uu_max", 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 33);
        drain();
        run_op("ss_min", 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               64'h0, 64'h8000_0000_0000_0000, -1);
        drain();
        run_op("su", 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h2, -1);
        drain();
        run_op("word_ss", 1'b1, 2'b11, 64'hDEAD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002,
               64'h0, 64'hFFFF_FFFF_FFFF_FFFE, LAT_WORD_B2);
        drain();
        run_op("word_us", 1'b1, 2'b01, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h1, -1);
        drain();
        run_op("us_mix", 1'b0, 2'b01, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, -1);

        // backpressure: result and handshake held while out_ready stays low
        hold_hi = res_hi; hold_lo = res_lo;
        repeat (5) begin
            @(posedge clock); #1;
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_res", {res_hi, res_lo}, {hold_hi, hold_lo});
        end
        drain();
        chk("bp_after_valid", 128'(out_valid), 128'(0));
        chk("bp_after_ready", 128'(in_ready), 128'(1));
        chk("idle_holds_res", {res_hi, res_lo}, {hold_hi, hold_lo});

        // flush in the 10th BUSY cycle drops the op
        word = 1'b0; sign_mode = 2'b00; a = 64'h1234; b = 64'hFFFF_0000_0000_0001; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", 128'(seen), 128'(0));

        // flush together with a request in IDLE: not accepted
        in_valid = 1'b1; flush = 1'b1; a = 64'h9; b = 64'h9;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_idle_no_accept", 128'(seen), 128'(0));

        run_op("uu_3x5", 1'b0, 2'b00, 64'd3, 64'd5, 64'h0, 64'd15, -1);
        drain();
        run_op("uu_7x3", 1'b0, 2'b00, 64'd7, 64'd3, 64'h0, 64'd21, LAT_B3);

        // flush while DONE drops the pending result
        #0 flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_done_valid", 128'(out_valid), 128'(0));

        repeat (3) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
